// File: rtl/pid_param_bank_if.sv
// Command/response port of the PID parameter bank.
// The master is the command parser; the slave is the bank.
interface pid_param_bank_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 2
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [2+ADDR_W+DATA_W-1:0] cmd_word;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_W-1:0]          rsp_data;
    logic                       rsp_err;

    modport master (
        output cmd_valid, cmd_word, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_word, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/pid_param_bank.sv
// Addressed controller parameter bank: range-checked shadow writes, atomic commit
// into the active copy driving the PID core, and a response for every command.
module pid_param_bank #(
    parameter int                         DATA_W     = 14,
    parameter int                         NUM_REGS   = 4,
    parameter int                         ADDR_W     = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] DEFAULTS   = {14'h0000, 14'h0000, 14'h104C, 14'h1280},
    parameter logic [NUM_REGS-1:0]        LIMIT_MASK = 4'b0001,
    parameter logic [DATA_W-1:0]          LIM_MIN    = 14'h0DC0,
    parameter logic [DATA_W-1:0]          LIM_MAX    = 14'h3200
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    pid_param_bank_if.slave              bus,
    output logic [NUM_REGS*DATA_W-1:0]   o_reg_out,
    output logic                         o_commit_p,
    output logic                         o_pending,
    output logic [7:0]                   o_err_cnt
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_COMMIT  = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_RESTORE = 2'b11;

    localparam int               CMD_W       = 2 + ADDR_W + DATA_W;
    localparam logic [ADDR_W:0]  NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);

    logic [1:0]        r_state;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_shadow [NUM_REGS];
    logic [DATA_W-1:0] r_active [NUM_REGS];
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_commit_p;
    logic              r_pending;
    logic [7:0]        r_err_cnt;

    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_addr_ok;
    logic              w_in_range;
    logic              w_err;
    logic [DATA_W-1:0] w_rsp_data;

    assign w_op       = r_cmd[CMD_W-1 -: 2];
    assign w_addr     = r_cmd[DATA_W +: ADDR_W];
    assign w_data     = r_cmd[DATA_W-1:0];
    assign w_addr_ok  = {1'b0, w_addr} < NUM_REGS_EXT;
    assign w_in_range = (w_data >= LIM_MIN) && (w_data <= LIM_MAX);

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_err      = 1'b0;
        w_rsp_data = '0;
        case (w_op)
            OP_WRITE: begin
                w_err      = !w_addr_ok || (LIMIT_MASK[w_addr] && !w_in_range);
                w_rsp_data = w_data;
            end
            OP_READ: begin
                w_err = !w_addr_ok;
                if (w_addr_ok)
                    w_rsp_data = w_data[0] ? r_shadow[w_addr] : r_active[w_addr];
            end
            default: ;
        endcase
    end

    // NOTE: the register arrays are reset explicitly because the PID core must see DEFAULTS straight out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_commit_p  <= 1'b0;
            r_pending   <= 1'b0;
            r_err_cnt   <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= DEFAULTS[i*DATA_W +: DATA_W];
                r_active[i] <= DEFAULTS[i*DATA_W +: DATA_W];
            end
        end else begin
            r_commit_p <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cmd   <= bus.cmd_word;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_rsp_data;
                    r_rsp_err   <= w_err;
                    r_state     <= S_RESP;
                    if (w_err && r_err_cnt != 8'hFF)
                        r_err_cnt <= r_err_cnt + 8'd1;
                    case (w_op)
                        OP_WRITE: begin
                            if (!w_err) begin
                                r_shadow[w_addr] <= w_data;
                                r_pending        <= 1'b1;
                            end
                        end
                        OP_COMMIT: begin
                            r_active   <= r_shadow;
                            r_commit_p <= 1'b1;
                            r_pending  <= 1'b0;
                        end
                        OP_RESTORE: begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                r_shadow[i] <= DEFAULTS[i*DATA_W +: DATA_W];
                                r_active[i] <= DEFAULTS[i*DATA_W +: DATA_W];
                            end
                            r_commit_p <= 1'b1;
                            r_pending  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++)
            o_reg_out[i*DATA_W +: DATA_W] = r_active[i];
    end

    assign bus.cmd_ready = i_rst_n && (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign o_commit_p    = r_commit_p;
    assign o_pending     = r_pending;
    assign o_err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_pid_param_bank.sv
// Bench for pid_param_bank: directed vector table, multi-cycle corner sequences,
// and random commands checked against a register-file model of the bank.
module tb_pid_param_bank;
    localparam logic [1:0] OP_WR = 2'b00;
    localparam logic [1:0] OP_CM = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_RS = 2'b11;
    localparam logic [55:0] DEF4 = {14'h0000, 14'h0000, 14'h104C, 14'h1280};
    localparam logic [41:0] DEF3 = {14'h0000, 14'h104C, 14'h1280};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [55:0] reg_out;
    logic        commit_p, pending;
    logic [7:0]  err_cnt;
    logic [41:0] reg_out3;
    logic        commit_p3, pending3;
    logic [7:0]  err_cnt3;

    int n_cmp  = 0;
    int n_fail = 0;

    pid_param_bank_if #(.DATA_W(14), .ADDR_W(2)) bus ();
    pid_param_bank_if #(.DATA_W(14), .ADDR_W(2)) bus3 ();

    pid_param_bank dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
        .o_reg_out(reg_out), .o_commit_p(commit_p), .o_pending(pending), .o_err_cnt(err_cnt)
    );

    pid_param_bank #(.NUM_REGS(3), .DEFAULTS(DEF3), .LIMIT_MASK(3'b001)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus3),
        .o_reg_out(reg_out3), .o_commit_p(commit_p3), .o_pending(pending3), .o_err_cnt(err_cnt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out, got no event, expected one", name);
    endtask

    // Behavioural model: two register files plus pending flag and error count.
    logic [13:0] m_shadow [4];
    logic [13:0] m_active [4];
    logic        m_pending;
    int          m_errs;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = DEF4[i*14 +: 14];
            m_active[i] = DEF4[i*14 +: 14];
        end
        m_pending = 1'b0;
        m_errs    = 0;
    endtask

    function automatic logic [55:0] model_reg_out();
        logic [55:0] v;
        v = {m_active[3], m_active[2], m_active[1], m_active[0]};
        return v;
    endfunction

    task automatic model_apply(input logic [1:0] op, input logic [1:0] addr, input logic [13:0] data,
                               output logic [13:0] e_data, output logic e_err, output logic e_commit);
        e_data = 14'h0; e_err = 1'b0; e_commit = 1'b0;
        if (op == OP_WR) begin
            e_data = data;
            if (addr == 2'd0 && (data < 14'h0DC0 || data > 14'h3200)) e_err = 1'b1;
            else begin m_shadow[addr] = data; m_pending = 1'b1; end
        end else if (op == OP_RD) begin
            e_data = data[0] ? m_shadow[addr] : m_active[addr];
        end else begin
            if (op == OP_RS) model_reset_regs();
            else for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
            m_pending = 1'b0;
            e_commit  = 1'b1;
        end
        if (e_err) m_errs = m_errs + 1;
    endtask

    task automatic model_reset_regs();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = DEF4[i*14 +: 14];
            m_active[i] = DEF4[i*14 +: 14];
        end
    endtask

    // Full command on the main bank; called at posedge+1, returns at posedge+1 after the handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [13:0] data,
                          output logic [13:0] r_data, output logic r_err, output logic r_commit);
        int n;
        bus.cmd_word  = {op, addr, data};
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) timeout("cmd_ready");
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) timeout("rsp_valid");
        r_data   = bus.rsp_data;
        r_err    = bus.rsp_err;
        r_commit = commit_p;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_cmd3(input logic [1:0] op, input logic [1:0] addr, input logic [13:0] data,
                           output logic [13:0] r_data, output logic r_err);
        int n;
        bus3.cmd_word  = {op, addr, data};
        bus3.cmd_valid = 1'b1;
        n = 0;
        while (!bus3.cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) timeout("cmd_ready3");
        @(posedge clk); #1;
        bus3.cmd_valid = 1'b0;
        n = 0;
        while (!bus3.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) timeout("rsp_valid3");
        r_data = bus3.rsp_data;
        r_err  = bus3.rsp_err;
        bus3.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus3.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  addr;
        logic [13:0] data;
        logic [13:0] exp_data;
        logic        exp_err;
        logic        exp_commit;
        logic        exp_pending;
        logic [13:0] exp_reg0;
        logic [7:0]  exp_errcnt;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [13:0] d;
        logic        e, c;
        logic [13:0] e_data;
        logic        e_err, e_commit;
        int          n;

        vecs[0]  = '{OP_RD, 2'd0, 14'h0000, 14'h1280, 1'b0, 1'b0, 1'b0, 14'h1280, 8'd0};
        vecs[1]  = '{OP_WR, 2'd0, 14'h1400, 14'h1400, 1'b0, 1'b0, 1'b1, 14'h1280, 8'd0};
        vecs[2]  = '{OP_RD, 2'd0, 14'h0001, 14'h1400, 1'b0, 1'b0, 1'b1, 14'h1280, 8'd0};
        vecs[3]  = '{OP_CM, 2'd0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h1400, 8'd0};
        vecs[4]  = '{OP_WR, 2'd0, 14'h0DBF, 14'h0DBF, 1'b1, 1'b0, 1'b0, 14'h1400, 8'd1};
        vecs[5]  = '{OP_WR, 2'd0, 14'h3201, 14'h3201, 1'b1, 1'b0, 1'b0, 14'h1400, 8'd2};
        vecs[6]  = '{OP_RD, 2'd0, 14'h0001, 14'h1400, 1'b0, 1'b0, 1'b0, 14'h1400, 8'd2};
        vecs[7]  = '{OP_WR, 2'd0, 14'h0DC0, 14'h0DC0, 1'b0, 1'b0, 1'b1, 14'h1400, 8'd2};
        vecs[8]  = '{OP_WR, 2'd0, 14'h3200, 14'h3200, 1'b0, 1'b0, 1'b1, 14'h1400, 8'd2};
        vecs[9]  = '{OP_WR, 2'd1, 14'h3FFF, 14'h3FFF, 1'b0, 1'b0, 1'b1, 14'h1400, 8'd2};
        vecs[10] = '{OP_CM, 2'd3, 14'h2AAA, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h3200, 8'd2};
        vecs[11] = '{OP_RD, 2'd1, 14'h0000, 14'h3FFF, 1'b0, 1'b0, 1'b0, 14'h3200, 8'd2};
        vecs[12] = '{OP_RD, 2'd2, 14'h0000, 14'h0000, 1'b0, 1'b0, 1'b0, 14'h3200, 8'd2};
        vecs[13] = '{OP_RS, 2'd0, 14'h0000, 14'h0000, 1'b0, 1'b1, 1'b0, 14'h1280, 8'd2};
        vecs[14] = '{OP_RD, 2'd1, 14'h0000, 14'h104C, 1'b0, 1'b0, 1'b0, 14'h1280, 8'd2};

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;  bus.cmd_word = '0;  bus.rsp_ready = 1'b0;
        bus3.cmd_valid = 1'b0; bus3.cmd_word = '0; bus3.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", 64'(bus.cmd_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_commit_p", 64'(commit_p), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_reg_out", 64'(reg_out), 64'(DEF4));

        for (int i = 0; i < 15; i++) begin
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, d, e, c);
            check($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_commit", i), 64'(c), 64'(vecs[i].exp_commit));
            check($sformatf("vec%0d_commit_after", i), 64'(commit_p), 64'd0);
            check($sformatf("vec%0d_pending", i), 64'(pending), 64'(vecs[i].exp_pending));
            check($sformatf("vec%0d_reg0", i), 64'(reg_out[13:0]), 64'(vecs[i].exp_reg0));
            check($sformatf("vec%0d_errcnt", i), 64'(err_cnt), 64'(vecs[i].exp_errcnt));
        end
        check("restore_reg_out", 64'(reg_out), 64'(DEF4));

        // Stalled response: output must hold and a competing command must not be taken.
        bus.cmd_word = {OP_WR, 2'd1, 14'h0123};
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_word = {OP_WR, 2'd1, 14'h0456};
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) timeout("hold_rsp_valid");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold%0d_valid", i), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("hold%0d_data", i), 64'(bus.rsp_data), 64'h0123);
            check($sformatf("hold%0d_ready", i), 64'(bus.cmd_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("hold_released_valid", 64'(bus.rsp_valid), 64'd0);
        check("hold_released_ready", 64'(bus.cmd_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_extra_rsp", 64'(bus.rsp_valid), 64'd0);
        do_cmd(OP_RD, 2'd1, 14'h0001, d, e, c);
        check("hold_shadow1", 64'(d), 64'h0123);

        // Reset while a WRITE is executing: no response, everything back to defaults.
        bus.cmd_word = {OP_WR, 2'd0, 14'h2000};
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            check("rstexec_no_rsp", 64'(bus.rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        check("rstexec_reg_out", 64'(reg_out), 64'(DEF4));
        check("rstexec_pending", 64'(pending), 64'd0);
        do_cmd(OP_RD, 2'd0, 14'h0001, d, e, c);
        check("rstexec_shadow0", 64'(d), 64'h1280);
        do_cmd(OP_RD, 2'd1, 14'h0001, d, e, c);
        check("rstexec_shadow1", 64'(d), 64'h104C);

        // Random commands against the model.
        model_reset();
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  op;
            logic [1:0]  addr;
            logic [13:0] data;
            int          pick;
            pick = int'($urandom_range(0, 19));
            op   = (pick < 9) ? OP_WR : (pick < 15) ? OP_RD : (pick < 19) ? OP_CM : OP_RS;
            addr = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: data = 14'($urandom);
                1: data = 14'(32'h0DC0 + $urandom_range(0, 2) - 1);
                2: data = 14'(32'h3200 + $urandom_range(0, 2) - 1);
                default: data = 14'($urandom_range(32'h0DC0, 32'h3200));
            endcase
            do_cmd(op, addr, data, d, e, c);
            model_apply(op, addr, data, e_data, e_err, e_commit);
            check($sformatf("rnd%0d_data", i), 64'(d), 64'(e_data));
            check($sformatf("rnd%0d_err", i), 64'(e), 64'(e_err));
            check($sformatf("rnd%0d_commit", i), 64'(c), 64'(e_commit));
            check($sformatf("rnd%0d_reg_out", i), 64'(reg_out), 64'(model_reg_out()));
            check($sformatf("rnd%0d_pending", i), 64'(pending), 64'(m_pending));
            check($sformatf("rnd%0d_errcnt", i), 64'(err_cnt), 64'(m_errs > 255 ? 255 : m_errs));
        end

        // Three-register build: address 3 is out of range; error count saturates.
        do_cmd3(OP_WR, 2'd3, 14'h1000, d, e);
        check("nr3_wr_bad_err", 64'(e), 64'd1);
        check("nr3_pending", 64'(pending3), 64'd0);
        do_cmd3(OP_RD, 2'd3, 14'h0001, d, e);
        check("nr3_rd_bad_err", 64'(e), 64'd1);
        check("nr3_rd_bad_data", 64'(d), 64'd0);
        do_cmd3(OP_WR, 2'd2, 14'h3FFF, d, e);
        check("nr3_wr2_err", 64'(e), 64'd0);
        check("nr3_errcnt2", 64'(err_cnt3), 64'd2);
        for (int i = 0; i < 256; i++)
            do_cmd3(OP_WR, 2'd3, 14'h0000, d, e);
        check("nr3_errcnt_sat", 64'(err_cnt3), 64'hFF);
        do_cmd3(OP_RD, 2'd3, 14'h0000, d, e);
        check("nr3_sat_err", 64'(e), 64'd1);
        check("nr3_errcnt_hold", 64'(err_cnt3), 64'hFF);
        check("nr3_reg_out", 64'(reg_out3), 64'(DEF3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
